// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state type and op classification shared by alu_mc and its iterative core
package alu_pkg;
  localparam logic [4:0] OP_SLL = 5'd0, OP_SRL = 5'd1, OP_SRA = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5, OP_OR = 5'd6, OP_AND = 5'd7, OP_SLT = 5'd8, OP_SLTU = 5'd9;
  localparam logic [4:0] OP_LUI = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_iterative(input logic [4:0] op);
    return op inside {[OP_MUL:OP_REMU]};
  endfunction
endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes
// Ports: start loads mag1/mag2 and mode (0 = multiply, 1 = divide); done flags the final step;
// prod/quo/rem present the working register after the current step. Built only with ALU_MC_MDU_EN.
`ifdef ALU_MC_MDU_EN
module alu_mc_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [XLEN-1:0]   mag1,
  input  logic [XLEN-1:0]   mag2,
  output logic              done,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quo,
  output logic [XLEN-1:0]   rem
);
  localparam int CW = $clog2(XLEN) + 1;
  logic [2*XLEN-1:0] w, w_nxt;
  logic [XLEN-1:0] b;
  logic [XLEN:0] t;
  logic [CW-1:0] cnt;
  logic div;
  // Multiply: w = {partial sum, multiplier}; divide: w = {partial remainder, dividend/quotient}.
  // In divide mode t[XLEN] is the borrow of the trial subtraction.
  always_comb begin
    t = div ? w[2*XLEN-1:XLEN-1] - {1'b0, b} : {1'b0, w[2*XLEN-1:XLEN]} + (w[0] ? {1'b0, b} : '0);
    w_nxt = div ? (t[XLEN] ? {w[2*XLEN-2:0], 1'b0} : {t[XLEN-1:0], w[XLEN-2:0], 1'b1}) : {t, w[XLEN-1:1]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w <= '0;
      b <= '0;
      cnt <= '0;
      div <= 1'b0;
    end else if (start) begin
      w <= {{XLEN{1'b0}}, mag1};
      b <= mag2;
      cnt <= CW'(XLEN);
      div <= mode;
    end else if (cnt != '0) begin
      w <= w_nxt;
      cnt <= cnt - 1'b1;
    end
  assign done = cnt == CW'(1);
  assign prod = w_nxt;
  assign quo = w_nxt[XLEN-1:0];
  assign rem = w_nxt[2*XLEN-1:XLEN];
endmodule
`endif

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I/M ALU behind valid/ready handshakes (optional M ops via ALU_MC_MDU_EN)
// Ports: in_valid/in_ready/op/operand1/operand2 request side; out_valid/out_ready/result response
// side; busy high while an iterative multiply/divide runs. Without ALU_MC_MDU_EN, ops 16-23 yield 0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  state_t state, state_nxt;
  logic accept, iter_go, iter_done;
  logic [SW-1:0] shamt;
  logic [XLEN-1:0] base_res, fast_res, iter_res;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign shamt = operand2[SW-1:0];
  always_comb begin
    base_res = '0;
    case (op)
      OP_SLL:  base_res = operand1 << shamt;
      OP_SRL:  base_res = operand1 >> shamt;
      OP_SRA:  base_res = $unsigned($signed(operand1) >>> shamt);
      OP_ADD:  base_res = operand1 + operand2;
      OP_SUB:  base_res = operand1 - operand2;
      OP_XOR:  base_res = operand1 ^ operand2;
      OP_OR:   base_res = operand1 | operand2;
      OP_AND:  base_res = operand1 & operand2;
      OP_SLT:  base_res = XLEN'($signed(operand1) < $signed(operand2));
      OP_SLTU: base_res = XLEN'(operand1 < operand2);
      OP_LUI:  base_res = {operand2[XLEN-13:0], 12'b0};
      default: base_res = '0;
    endcase
  end
`ifdef ALU_MC_MDU_EN
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic is_div, div0, ovf, s1, s2, neg_q, s1_q;
  logic [4:0] op_q;
  logic [XLEN-1:0] mag1, mag2, quo, rem;
  logic [2*XLEN-1:0] prod, prod_s;
  assign is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign div0 = is_div && operand2 == '0;
  assign ovf = op inside {OP_DIV, OP_REM} && operand1 == MIN && operand2 == '1;
  assign iter_go = accept && is_iterative(op) && !div0 && !ovf;
  assign s1 = operand1[XLEN-1] && op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign s2 = operand2[XLEN-1] && op inside {OP_MULH, OP_DIV, OP_REM};
  assign mag1 = s1 ? -operand1 : operand1;
  assign mag2 = s2 ? -operand2 : operand2;
  // Divide-by-zero and signed overflow bypass the iterative core and finish in one cycle.
  assign fast_res = div0 ? (op inside {OP_DIV, OP_DIVU} ? '1 : operand1) :
                    ovf  ? (op == OP_DIV ? operand1 : '0) : base_res;
  alu_mc_iter #(.XLEN(XLEN)) u_iter (
    .clk(clk), .rst(rst), .start(iter_go), .mode(is_div), .mag1(mag1), .mag2(mag2),
    .done(iter_done), .prod(prod), .quo(quo), .rem(rem)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      neg_q <= 1'b0;
      s1_q <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      neg_q <= s1 ^ s2;
      s1_q <= s1;
    end
  // Product/quotient take the XOR of operand signs; the remainder follows the dividend.
  assign prod_s = neg_q ? -prod : prod;
  assign iter_res = op_q == OP_MUL ? prod_s[XLEN-1:0] :
                    op_q inside {OP_MULH, OP_MULHSU, OP_MULHU} ? prod_s[2*XLEN-1:XLEN] :
                    op_q inside {OP_DIV, OP_DIVU} ? (neg_q ? -quo : quo) : (s1_q ? -rem : rem);
  assign busy = state == BUSY;
`else
  assign iter_go = 1'b0;
  assign iter_done = 1'b0;
  assign fast_res = base_res;
  assign iter_res = '0;
  assign busy = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = iter_go ? BUSY : DONE;
    else if (state == DONE && out_ready) state_nxt = IDLE;
    else if (state == BUSY && iter_done) state_nxt = DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) result <= '0;
    else if (accept && !iter_go) result <= fast_res;
    else if (state == BUSY && iter_done) result <= iter_res;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc (XLEN=32), expectations follow the ALU_MC_MDU_EN build
module tb_alu_mc;
  import alu_pkg::*;
`ifdef ALU_MC_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [4:0] op = '0;
  logic [31:0] operand1 = '0, operand2 = '0, result;
  int n_vec = 0, n_err = 0, lat, nb;
  alu_mc #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand1(operand1), .operand2(operand2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    nb = 0;
    while (!out_valid && lat < 100) begin
      nb += int'(busy);
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  task automatic vec(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_lat, input int exp_busy);
    run(o, a, b);
    chk(tag, result, exp);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, nb, exp_busy);
    take();
  endtask
  initial begin
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1 chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
    vec("sll", OP_SLL, 32'h8000_0010, 32'h24, 32'h0000_0100, 1, 0);
    vec("srl", OP_SRL, 32'h8000_0010, 32'h24, 32'h0800_0001, 1, 0);
    vec("sra", OP_SRA, 32'h8000_0010, 32'h24, 32'hF800_0001, 1, 0);
    vec("add", OP_ADD, 32'h8000_0010, 32'h24, 32'h8000_0034, 1, 0);
    vec("sub", OP_SUB, 32'h8000_0010, 32'h24, 32'h7FFF_FFEC, 1, 0);
    vec("xor", OP_XOR, 32'h8000_0010, 32'h24, 32'h8000_0034, 1, 0);
    vec("or", OP_OR, 32'h8000_0010, 32'h24, 32'h8000_0034, 1, 0);
    vec("and", OP_AND, 32'h8000_0010, 32'h24, 32'h0000_0000, 1, 0);
    vec("slt", OP_SLT, 32'h8000_0010, 32'h24, 32'd1, 1, 0);
    vec("sltu", OP_SLTU, 32'h8000_0010, 32'h24, 32'd0, 1, 0);
    vec("lui", OP_LUI, 32'h8000_0010, 32'h24, 32'h0002_4000, 1, 0);
    vec("unknown", 5'd11, 32'h8000_0010, 32'h24, 32'd0, 1, 0);
    vec("mulh", OP_MULH, 32'hFFFF_FFFE, 32'd3, MDU ? 32'hFFFF_FFFF : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    vec("mul", OP_MUL, 32'hFFFF_FFFE, 32'd3, MDU ? 32'hFFFF_FFFA : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    vec("mul_3x4", OP_MUL, 32'd3, 32'd4, MDU ? 32'd12 : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    vec("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MDU ? 32'hFFFF_FFFE : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    vec("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MDU ? 32'hFFFF_FFFF : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    vec("div_by0", OP_DIV, 32'd7, 32'd0, MDU ? 32'hFFFF_FFFF : 32'd0, 1, 0);
    vec("rem_by0", OP_REM, 32'd7, 32'd0, MDU ? 32'd7 : 32'd0, 1, 0);
    vec("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, MDU ? 32'h8000_0000 : 32'd0, 1, 0);
    vec("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    vec("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, MDU ? 32'hFFFF_FFFD : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    vec("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, MDU ? 32'hFFFF_FFFF : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    vec("divu", OP_DIVU, 32'd100, 32'd7, MDU ? 32'd14 : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    vec("remu", OP_REMU, 32'd100, 32'd7, MDU ? 32'd2 : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    run(OP_ADD, 32'd1, 32'd2);
    chk("bp_first", result, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("bp_hold_result", result, 32'd3);
      chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    op = OP_ADD;
    operand1 = 32'd5;
    operand2 = 32'd6;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk("bp_same_cycle_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_next_result", result, 32'd11);
    take();
    op = MDU ? OP_DIVU : OP_ADD;
    operand1 = 32'd1000;
    operand2 = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", {31'b0, busy}, {31'b0, MDU});
    rst = 1'b1;
    #1 chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    vec("after_rst_add", OP_ADD, 32'd2, 32'd2, 32'd4, 1, 0);
    vec("after_rst_divu", OP_DIVU, 32'd1000, 32'd3, MDU ? 32'd333 : 32'd0, MDU ? 33 : 1, MDU ? 32 : 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
